data_in32: RTL

Serial-to-parallel input stage that collects 32-bit words into one 256-bit block and hands the block to the datapath core over a valid/ready handshake. It is the input-side counterpart of the 256-bit-to-8×32-bit output stage: the core consumes `PDO` in the same word order that the output stage emits on DO0..DO7. A block can be closed early with `di_last`; the unused words are zero-padded and the word count is reported with the block.

---
 rtl/data_io32_pkg.sv | 21 ++
 rtl/data_in32.sv | 118 +++++++++++
 2 files changed

// File: rtl/data_io32_pkg.sv
// ---------------------------------------------------------------------------
// data_io32_pkg
// Shared definitions for the 32-bit word <-> 256-bit block I/O stages
// (data_in32 on the input side, the 8x32 output stage on the other side).
//   WORD_W  : width of one serial word
//   N_WORDS : words per block
//   BLK_W   : assembled block width
//   blk_state_e : block state, FILL (collecting words) / FULL (block presented)
// ---------------------------------------------------------------------------
package data_io32_pkg;

  localparam int WORD_W  = 32;
  localparam int N_WORDS = 8;
  localparam int BLK_W   = 256;

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } blk_state_e;

endpackage

// File: rtl/data_in32.sv
// ---------------------------------------------------------------------------
// data_in32
// Serial-to-parallel input stage: collects WORD_W-bit words into one
// WORD_W*N_WORDS block and hands it to the core over valid/ready.
// A block may be closed early with di_last; slots above the last word are
// zeroed at close and the real word count is reported in pdo_words.
//
// Ports
//   CLK       in   system clock, rising edge
//   rst       in   synchronous active-high reset
//   DI        in   input word
//   di_valid  in   DI holds a valid word
//   di_last   in   (with di_valid) this word closes the block
//   di_ready  out  a word can be accepted this cycle (registered)
//   flush     in   discard a partially filled block (ignored while FULL)
//   PDO       out  assembled block, word k at PDO[WORD_W*k +: WORD_W]
//   pdo_words out  number of real words in PDO (1..N_WORDS)
//   pdo_valid out  PDO/pdo_words valid (registered)
//   pdo_ready in   core accepts the block
// ---------------------------------------------------------------------------
module data_in32 #(
  parameter int WORD_W  = data_io32_pkg::WORD_W,
  parameter int N_WORDS = data_io32_pkg::N_WORDS
) (
  input  logic                          CLK,
  input  logic                          rst,
  input  logic [WORD_W-1:0]             DI,
  input  logic                          di_valid,
  input  logic                          di_last,
  output logic                          di_ready,
  input  logic                          flush,
  output logic [WORD_W*N_WORDS-1:0]     PDO,
  output logic [$clog2(N_WORDS+1)-1:0]  pdo_words,
  output logic                          pdo_valid,
  input  logic                          pdo_ready
);

  import data_io32_pkg::*;

  localparam int CNT_W   = $clog2(N_WORDS);
  localparam int WORDS_W = $clog2(N_WORDS+1);
  localparam int PDO_W   = WORD_W*N_WORDS;

  blk_state_e            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [PDO_W-1:0]      pdo_q, pdo_d;
  logic [WORDS_W-1:0]    words_q, words_d;
  logic                  di_ready_q, di_ready_d;
  logic                  pdo_valid_q, pdo_valid_d;
  logic [PDO_W-1:0]      pad_mask;

  // Slots strictly above the current write slot; cleared when a block closes.
  generate
    for (genvar gi = 0; gi < N_WORDS; gi++) begin : g_pad
      assign pad_mask[gi*WORD_W +: WORD_W] =
        (CNT_W'(gi) > cnt_q) ? {WORD_W{1'b1}} : {WORD_W{1'b0}};
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pdo_d   = pdo_q;
    words_d = words_q;
    case (state_q)
      FILL: begin
        if (flush) begin
          // flush wins over a word presented in the same cycle
          cnt_d = '0;
        end else if (di_valid && di_ready_q) begin
          pdo_d[int'(cnt_q)*WORD_W +: WORD_W] = DI;
          cnt_d = cnt_q + CNT_W'(1);
          if (di_last || (cnt_q == CNT_W'(N_WORDS-1))) begin
            pdo_d   = pdo_d & ~pad_mask;
            words_d = WORDS_W'(cnt_q) + WORDS_W'(1);
            state_d = FULL;
          end
        end
      end
      FULL: begin
        // flush is deliberately not looked at here: a presented block stays
        if (pdo_valid_q && pdo_ready) begin
          state_d = FILL;
          cnt_d   = '0;
        end
      end
      default: state_d = FILL;
    endcase
    // Handshake flags are registered copies of the next state, so neither
    // output has a combinational path from any input.
    di_ready_d  = (state_d == FILL);
    pdo_valid_d = (state_d == FULL);
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      state_q     <= FILL;
      cnt_q       <= '0;
      pdo_q       <= '0;
      words_q     <= '0;
      di_ready_q  <= 1'b0;
      pdo_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pdo_q       <= pdo_d;
      words_q     <= words_d;
      di_ready_q  <= di_ready_d;
      pdo_valid_q <= pdo_valid_d;
    end
  end

  assign di_ready  = di_ready_q;
  assign pdo_valid = pdo_valid_q;
  assign PDO       = pdo_q;
  assign pdo_words = words_q;

endmodule
